// File: rtl/fsqrt_pipe_if.sv
// Handshake bundle for fsqrt_pipe: operand channel in, result channel out.
// out_flags is present only when FSQRT_FLAGS_EN is defined.
interface fsqrt_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_y;
`ifdef FSQRT_FLAGS_EN
   logic [1:0]  out_flags;

   modport master (output in_valid, in_x, out_ready, input in_ready, out_valid, out_y, out_flags);
   modport slave  (input in_valid, in_x, out_ready, output in_ready, out_valid, out_y, out_flags);
`else
   modport master (output in_valid, in_x, out_ready, input in_ready, out_valid, out_y);
   modport slave  (input in_valid, in_x, out_ready, output in_ready, out_valid, out_y);
`endif
endinterface

// File: rtl/fsqrt_pipe.sv
// Three-stage fp32 square root: table lookup plus linear interpolation, valid/ready
// with a global stall. Define FSQRT_FLAGS_EN to add out_flags = {invalid, denorm_flushed}.
module fsqrt_pipe #(
   parameter int IDX_W  = 9,
   parameter int DX_W   = 4,
   parameter int GRAD_W = 13
) (
   input logic         clk,
   input logic         rst,
   fsqrt_pipe_if.slave bus
);
   localparam int DEPTH  = 2 ** (IDX_W + 1);
   localparam int WORD_W = 23 + GRAD_W;
   localparam int PROD_W = GRAD_W + DX_W;

   function automatic logic [63:0] isqrt(input logic [63:0] v);
      logic [63:0] r;
      logic [63:0] t;
      r = '0;
      for (int b = 31; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= v) r = t;
      end
      return r;
   endfunction

   // Entry = {frac of sqrt at segment start, rise across the segment}; the upper half
   // of the table is sqrt(2m) for odd unbiased exponents. Rise is clamped to GRAD_W bits.
   function automatic logic [WORD_W-1:0] tbl_word(input int idx);
      logic [63:0] base;
      logic [63:0] v0;
      logic [63:0] v1;
      logic [63:0] grad;
      int          sh;
      sh   = (idx >= 2 ** IDX_W) ? 47 - IDX_W : 46 - IDX_W;
      base = 64'(2 ** IDX_W + (idx % (2 ** IDX_W)));
      v0   = isqrt(base << sh);
      v1   = isqrt((base + 64'd1) << sh);
      grad = v1 - v0;
      if (grad > 64'(2 ** GRAD_W - 1)) grad = 64'(2 ** GRAD_W - 1);
      return {v0[22:0], grad[GRAD_W-1:0]};
   endfunction

   logic [WORD_W-1:0] rom [DEPTH];
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam logic [WORD_W-1:0] WORD = tbl_word(gi);
      assign rom[gi] = WORD;
   end

   logic en;
   logic s0_valid_reg, s1_valid_reg, s2_valid_reg;
   logic [31:0] s0_x_reg;
   logic        s1_byp_reg;
   logic [31:0] s1_byp_y_reg;
   logic [7:0]  s1_ey_reg;
   logic [DX_W-1:0] s1_dx_reg;
   logic [WORD_W-1:0] tbl_q_reg;
   logic [31:0] out_y_reg;

   assign en           = !s2_valid_reg || bus.out_ready;
   assign bus.in_ready = en;
   assign bus.out_valid = s2_valid_reg;
   assign bus.out_y    = out_y_reg;

   // S0 decode on the registered operand
   logic        sign;
   logic [7:0]  expo;
   logic [22:0] frac;
   logic [IDX_W:0] addr;
   logic [DX_W-1:0] dx_next;
   logic signed [8:0] e_half;
   logic [7:0]  ey_next;
   logic        byp_next;
   logic [31:0] byp_y_next;

   assign sign    = s0_x_reg[31];
   assign expo    = s0_x_reg[30:23];
   assign frac    = s0_x_reg[22:0];
   assign addr    = {~expo[0], frac[22 -: IDX_W]};
   assign dx_next = frac[22-IDX_W -: DX_W];
   assign e_half  = ($signed({1'b0, expo}) - 9'sd127) >>> 1;
   assign ey_next = e_half[7:0] + 8'd127;

   always_comb begin
      byp_next   = 1'b1;
      byp_y_next = 32'h7FC0_0000;
      if (expo == 8'd0)                          byp_y_next = {sign, 31'b0};
      else if (expo == 8'hFF && frac != 23'd0)   byp_y_next = 32'h7FC0_0000;
      else if (sign)                             byp_y_next = 32'h7FC0_0000;
      else if (expo == 8'hFF)                    byp_y_next = 32'h7F80_0000;
      else                                       byp_next   = 1'b0;
   end

   // Table read is its own enable-only register so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (en) tbl_q_reg <= rom[addr];
   end

   // S2 interpolation
   logic [PROD_W-1:0] prod;
   logic [23:0]       sum;
   logic [22:0]       frac_y;

   assign prod   = PROD_W'(tbl_q_reg[GRAD_W-1:0]) * PROD_W'(s1_dx_reg);
   assign sum    = {1'b0, tbl_q_reg[WORD_W-1 -: 23]} + 24'(prod >> DX_W);
   assign frac_y = sum[23] ? 23'h7F_FFFF : sum[22:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid_reg <= 1'b0;
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         out_y_reg    <= 32'd0;
      end else if (en) begin
         s0_valid_reg <= bus.in_valid;
         s0_x_reg     <= bus.in_x;
         s1_valid_reg <= s0_valid_reg;
         s1_byp_reg   <= byp_next;
         s1_byp_y_reg <= byp_y_next;
         s1_ey_reg    <= ey_next;
         s1_dx_reg    <= dx_next;
         s2_valid_reg <= s1_valid_reg;
         out_y_reg    <= s1_byp_reg ? s1_byp_y_reg : {1'b0, s1_ey_reg, frac_y};
      end
   end

`ifdef FSQRT_FLAGS_EN
   logic [1:0] flags_next;
   logic [1:0] s1_flags_reg;
   logic [1:0] s2_flags_reg;

   // Quiet NaNs pass without raising invalid, even when negative
   always_comb begin
      flags_next = 2'b00;
      if (expo == 8'd0)                        flags_next = {1'b0, frac != 23'd0};
      else if (expo == 8'hFF && frac != 23'd0) flags_next = {~frac[22], 1'b0};
      else if (sign)                           flags_next = 2'b10;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_flags_reg <= 2'b00;
         s2_flags_reg <= 2'b00;
      end else if (en) begin
         s1_flags_reg <= flags_next;
         s2_flags_reg <= s1_flags_reg;
      end
   end

   assign bus.out_flags = s2_valid_reg ? s2_flags_reg : 2'b00;
`endif
endmodule

// File: tb/tb_fsqrt_pipe.sv
// Self-checking bench for fsqrt_pipe: vector table, backpressure, throughput and
// mid-operation reset, with a queue scoreboard fed by an independent real-valued model.
`timescale 1ns/1ps
module tb_fsqrt_pipe;
   localparam int IDX_W  = 9;
   localparam int DX_W   = 4;
   localparam int GRAD_W = 13;
   localparam int DEPTH  = 2 ** (IDX_W + 1);
   // Mantissa bits below the interpolation offset are ignored and the odd-exponent
   // slope is clamped to GRAD_W bits, so accuracy is bounded well above 2 ulp.
   localparam real ERR_ULP = 4096.0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fsqrt_pipe_if bus();
   fsqrt_pipe #(.IDX_W(IDX_W), .DX_W(DX_W), .GRAD_W(GRAD_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [1:0]  flags;
      int          t_acc;
      bit          chk_lat;
      bit          chk_acc;
   } exp_t;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [1:0]  flags;
   } vec_t;

   exp_t sb[$];
   exp_t none;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_emit  = 0;
   logic prev_stall = 1'b0;
   logic [31:0] prev_y = 32'd0;
   int   gconst[DEPTH];
   int   ggrad[DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic real pow2(input int n);
      real r;
      r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp_val(input logic [31:0] v);
      return (1.0 + real'(v[22:0]) / 8388608.0) * pow2(int'(v[30:23]) - 127);
   endfunction

   // Golden model for positive normal operands
   function automatic exp_t model(input logic [31:0] x);
      exp_t r;
      int e, u, k, idx, dx, s;
      e   = int'(x[30:23]);
      idx = ((e % 2 == 0) ? 2 ** IDX_W : 0) + int'(x[22:0] >> (23 - IDX_W));
      dx  = int'(x[22:0] >> (23 - IDX_W - DX_W)) % (2 ** DX_W);
      s   = gconst[idx] + (ggrad[idx] * dx) / (2 ** DX_W);
      if (s > 8388607) s = 8388607;
      u   = e - 127;
      k   = (u >= 0) ? u / 2 : -((1 - u) / 2);
      r.x = x;
      r.y = {1'b0, 8'(k + 127), 23'(s)};
      r.flags   = 2'b00;
      r.t_acc   = 0;
      r.chk_lat = 1'b0;
      r.chk_acc = 1'b0;
      return r;
   endfunction

   function automatic logic [31:0] rand_normal();
      return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
   endfunction

   // One clock cycle: drive at the falling edge, sample 1 ns later, score the handshakes
   task automatic step(input logic r, input logic v, input logic [31:0] x, input logic rdy,
                       input exp_t e, output logic accepted);
      exp_t got;
      real  err;
      @(negedge clk);
      rst = r;
      bus.in_valid  = v;
      bus.in_x      = x;
      bus.out_ready = rdy;
      #1;
      cyc++;
      accepted = 1'b0;
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, !(bus.out_valid && !rdy)});
      if (prev_stall) begin
         check("stall_hold_y", bus.out_y, prev_y);
         check("stall_hold_valid", {31'b0, bus.out_valid}, 32'd1);
      end
`ifdef FSQRT_FLAGS_EN
      if (!bus.out_valid) check("flags_idle", {30'b0, bus.out_flags}, 32'd0);
`endif
      prev_stall = !r && bus.out_valid && !rdy;
      prev_y     = bus.out_y;
      if (!r && v && bus.in_ready) begin
         e.x = x;
         e.t_acc = cyc;
         sb.push_back(e);
         accepted = 1'b1;
      end
      if (!r && bus.out_valid && rdy) begin
         n_emit++;
         if (sb.size() == 0) begin
            check("spurious_out", bus.out_y, 32'hxxxx_xxxx);
         end else begin
            got = sb.pop_front();
            check($sformatf("y(x=%h)", got.x), bus.out_y, got.y);
`ifdef FSQRT_FLAGS_EN
            check($sformatf("flags(x=%h)", got.x), {30'b0, bus.out_flags}, {30'b0, got.flags});
`endif
            if (got.chk_lat) check("latency", 32'(cyc - got.t_acc), 32'd3);
            if (got.chk_acc) begin
               err = fp_val(bus.out_y) - $sqrt(fp_val(got.x));
               if (err < 0.0) err = -err;
               err = err / pow2(int'(got.y[30:23]) - 150);
               n_tests++;
               if (err > ERR_ULP) begin
                  n_fail++;
                  $display("FAIL accuracy(x=%h): got %h, error %f ulp, limit %f", got.x, bus.out_y, err, ERR_ULP);
               end
            end
         end
      end
   endtask

   task automatic drain(input int budget);
      logic acc;
      int   n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         step(1'b0, 1'b0, 32'd0, 1'b1, none, acc);
         n++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[11];
      exp_t e;
      logic acc;
      logic rdy;
      logic [31:0] xs;
      int   sent, k, start, n_acc;
      real  kf, m0, v0, v1;
      int   g;

      vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 2'b00};
      vecs[1]  = '{32'h3F80_0000, 32'h3F80_0000, 2'b00};
      vecs[2]  = '{32'h4110_0000, 32'h4040_0000, 2'b00};
      vecs[3]  = '{32'h8000_0000, 32'h8000_0000, 2'b00};
      vecs[4]  = '{32'h0000_0001, 32'h0000_0000, 2'b01};
      vecs[5]  = '{32'hC080_0000, 32'h7FC0_0000, 2'b10};
      vecs[6]  = '{32'h7F80_0000, 32'h7F80_0000, 2'b00};
      vecs[7]  = '{32'h7F80_0001, 32'h7FC0_0000, 2'b10};
      vecs[8]  = '{32'h0080_0000, 32'h2000_0000, 2'b00};
      vecs[9]  = '{32'h7FC0_0000, 32'h7FC0_0000, 2'b00};
      vecs[10] = '{32'h3E80_0000, 32'h3F00_0000, 2'b00};

      for (int i = 0; i < DEPTH; i++) begin
         kf = (i >= 2 ** IDX_W) ? 2.0 : 1.0;
         m0 = 1.0 + real'(i % (2 ** IDX_W)) / real'(2 ** IDX_W);
         v0 = $floor($sqrt(kf * m0) * 8388608.0);
         v1 = $floor($sqrt(kf * (m0 + 1.0 / real'(2 ** IDX_W))) * 8388608.0);
         gconst[i] = int'(v0) - 8388608;
         g = int'(v1 - v0);
         ggrad[i] = (g > 2 ** GRAD_W - 1) ? 2 ** GRAD_W - 1 : g;
      end

      none = '{32'd0, 32'd0, 2'b00, 0, 1'b0, 1'b0};
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_x = 32'd0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, none, acc);
      step(1'b0, 1'b0, 32'd0, 1'b0, none, acc);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_out_y", bus.out_y, 32'd0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef FSQRT_FLAGS_EN
      check("rst_out_flags", {30'b0, bus.out_flags}, 32'd0);
`endif

      // Exact squares and special operands, back to back
      for (int i = 0; i < 11; i++) begin
         e = none;
         e.y = vecs[i].y;
         e.flags = vecs[i].flags;
         e.chk_lat = 1'b1;
         step(1'b0, 1'b1, vecs[i].x, 1'b1, e, acc);
         check("vec_accept", {31'b0, acc}, 32'd1);
      end
      drain(20);

      // Backpressure: 16 operands, out_ready = 1,0,0,1 repeating
      sent = 0; k = 0; start = n_emit;
      xs = rand_normal();
      while ((sent < 16 || sb.size() != 0) && k < 300) begin
         rdy = (k % 4 == 0) || (k % 4 == 3);
         if (sent < 16) begin
            e = model(xs);
            step(1'b0, 1'b1, xs, rdy, e, acc);
            if (acc) begin
               sent++;
               xs = rand_normal();
            end
         end else begin
            step(1'b0, 1'b0, 32'd0, rdy, none, acc);
         end
         k++;
      end
      check("bp_results", 32'(n_emit - start), 32'd16);
      drain(10);

      // Throughput: 1000 positive normals at full rate, range ends first
      start = n_emit; n_acc = 0;
      for (int i = 0; i < 1000; i++) begin
         xs = (i == 0) ? 32'h0080_0000 : (i == 1) ? 32'h7F7F_FFFF : rand_normal();
         e = model(xs);
         e.chk_lat = 1'b1;
         e.chk_acc = 1'b1;
         step(1'b0, 1'b1, xs, 1'b1, e, acc);
         if (acc) n_acc++;
      end
      repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, none, acc);
      check("tp_accepts", 32'(n_acc), 32'd1000);
      check("tp_results", 32'(n_emit - start), 32'd1000);
      drain(10);

      // Reset with three operands in flight
      for (int i = 0; i < 3; i++) begin
         xs = rand_normal();
         step(1'b0, 1'b1, xs, 1'b0, model(xs), acc);
      end
      step(1'b1, 1'b0, 32'd0, 1'b0, none, acc);
      sb.delete();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'd0, 1'b1, none, acc);
         check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
         if (i == 0) check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      end
      e = model(32'h4080_0000);
      e.chk_lat = 1'b1;
      step(1'b0, 1'b1, 32'h4080_0000, 1'b1, e, acc);
      check("midrst_accept", {31'b0, acc}, 32'd1);
      drain(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
